// File: rtl/hit_receiver.sv
// Victim-side hit receiver: edge-detects the attack bus, accumulates damage,
// launches a signed knockback vector and sequences hitstun then invulnerability.
module hit_receiver #(
  parameter logic [23:0] TICK_DIV      = 24'd833333,
  parameter logic [7:0]  HITSTUN_TICKS = 8'd20,
  parameter logic [7:0]  INVULN_TICKS  = 8'd30,
  parameter logic [9:0]  DMG_MAX       = 10'd999
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] attack,
  input  logic [31:0] attackerpos,
  input  logic [31:0] victimpos,
  input  logic        clear_damage,
  output logic [9:0]  damage,
  output logic [31:0] knockback,
  output logic        hitstun,
  output logic        invulnerable,
  output logic [3:0]  hit_type,
  output logic        hit_pulse,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HITSTUN = 2'd1,
    INVULN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               prev_hit_q;
  logic [23:0]        tick_cnt_q, tick_cnt_d;
  logic [7:0]         remaining_q, remaining_d;
  logic [9:0]         damage_q, damage_d;
  logic signed [15:0] vx_q, vx_d, vy_q, vy_d;
  logic [3:0]         hit_type_q, hit_type_d;
  logic               hit_pulse_q, hit_pulse_d;

  logic [3:0]         hit_idx;
  logic               tick, accept;
  logic [9:0]         dmg_base, dmg_new;
  logic [10:0]        dmg_sum, mag_sum;
  logic [6:0]         mag;
  logic signed [15:0] mag_s, half_s;
  logic               unused_bits;

  assign unused_bits = ^{attack[31:11], attackerpos[15:0], victimpos[15:0]};

  function automatic logic [4:0] dmg_of(input logic [3:0] idx);
    case (idx)
      4'd1:    dmg_of = 5'd15;
      4'd2:    dmg_of = 5'd14;
      4'd3:    dmg_of = 5'd16;
      4'd4:    dmg_of = 5'd16;
      4'd5:    dmg_of = 5'd3;
      4'd6:    dmg_of = 5'd8;
      4'd7:    dmg_of = 5'd10;
      4'd8:    dmg_of = 5'd9;
      4'd9:    dmg_of = 5'd9;
      4'd10:   dmg_of = 5'd7;
      default: dmg_of = 5'd0;
    endcase
  endfunction

  function automatic logic [6:0] kb_of(input logic [3:0] idx);
    if (idx >= 4'd1 && idx <= 4'd4) kb_of = 7'd8;
    else if (idx == 4'd5)           kb_of = 7'd1;
    else                            kb_of = 7'd4;
  endfunction

  // One frame tick of friction: magnitude shrinks by one, sign is preserved.
  function automatic logic signed [15:0] decay(input logic signed [15:0] v);
    if (v > 16'sd0)      decay = v - 16'sd1;
    else if (v < 16'sd0) decay = v + 16'sd1;
    else                 decay = v;
  endfunction

  // Lowest set type bit wins when several are asserted together.
  always_comb begin
    hit_idx = 4'd0;
    for (int i = 10; i >= 1; i--)
      if (attack[i]) hit_idx = 4'(i);
  end

  assign tick   = (tick_cnt_q == TICK_DIV - 24'd1);
  assign accept = attack[0] & ~prev_hit_q & (hit_idx != 4'd0) & (state_q == IDLE);

  // A stock loss in the same cycle as a hit clears first, then adds the hit.
  assign dmg_base = clear_damage ? 10'd0 : damage_q;
  assign dmg_sum  = {1'b0, dmg_base} + {6'd0, dmg_of(hit_idx)};
  assign dmg_new  = (dmg_sum > {1'b0, DMG_MAX}) ? DMG_MAX : dmg_sum[9:0];
  assign mag_sum  = {4'd0, kb_of(hit_idx)} + {5'd0, dmg_new[9:4]};
  assign mag      = (mag_sum > 11'd127) ? 7'd127 : mag_sum[6:0];
  assign mag_s    = $signed({9'd0, mag});
  assign half_s   = $signed({10'd0, mag[6:1]});

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick ? 24'd0 : tick_cnt_q + 24'd1;
    remaining_d = remaining_q;
    damage_d    = clear_damage ? 10'd0 : damage_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    hit_type_d  = hit_type_q;
    hit_pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          damage_d    = dmg_new;
          hit_type_d  = hit_idx;
          hit_pulse_d = 1'b1;
          state_d     = HITSTUN;
          tick_cnt_d  = 24'd0;
          remaining_d = HITSTUN_TICKS;
          case (hit_idx)
            4'd1, 4'd6: begin vx_d = 16'sd0; vy_d = mag_s;  end
            4'd2, 4'd7: begin vx_d = 16'sd0; vy_d = -mag_s; end
            4'd3, 4'd8: begin vx_d = -mag_s; vy_d = 16'sd0; end
            4'd4, 4'd9: begin vx_d = mag_s;  vy_d = 16'sd0; end
            default: begin
              vx_d = (victimpos[31:16] >= attackerpos[31:16]) ? mag_s : -mag_s;
              vy_d = half_s;
            end
          endcase
        end
      end
      HITSTUN: begin
        if (tick) begin
          if (remaining_q <= 8'd1) begin
            vx_d        = 16'sd0;
            vy_d        = 16'sd0;
            state_d     = INVULN;
            remaining_d = INVULN_TICKS;
          end else begin
            remaining_d = remaining_q - 8'd1;
            vx_d        = decay(vx_q);
            vy_d        = decay(vy_q);
          end
        end
      end
      INVULN: begin
        if (tick) begin
          if (remaining_q <= 8'd1) begin
            state_d     = IDLE;
            remaining_d = 8'd0;
          end else begin
            remaining_d = remaining_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      prev_hit_q  <= 1'b0;
      tick_cnt_q  <= 24'd0;
      remaining_q <= 8'd0;
      damage_q    <= 10'd0;
      vx_q        <= 16'sd0;
      vy_q        <= 16'sd0;
      hit_type_q  <= 4'd0;
      hit_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_hit_q  <= attack[0];
      tick_cnt_q  <= tick_cnt_d;
      remaining_q <= remaining_d;
      damage_q    <= damage_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      hit_type_q  <= hit_type_d;
      hit_pulse_q <= hit_pulse_d;
    end
  end

  assign damage       = damage_q;
  assign knockback    = {vx_q, vy_q};
  assign hitstun      = (state_q == HITSTUN);
  assign invulnerable = (state_q != IDLE);
  assign hit_type     = hit_type_q;
  assign hit_pulse    = hit_pulse_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_hit_receiver.sv
// Bench for hit_receiver: directed scenarios with literal expectations, then
// random traffic, all shadowed by a frame-level behavioural model.
module tb_hit_receiver;
  localparam logic [23:0] TD = 24'd4;
  localparam logic [7:0]  HS = 8'd3;
  localparam logic [7:0]  IV = 8'd2;
  localparam logic [9:0]  DM = 10'd999;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] attack = '0, attackerpos = '0, victimpos = '0;
  logic        clear_damage = 1'b0;
  logic [9:0]  damage;
  logic [31:0] knockback;
  logic        hitstun, invulnerable, hit_pulse;
  logic [3:0]  hit_type;
  logic [1:0]  dbg_state;

  always #5 clock = ~clock;

  hit_receiver #(.TICK_DIV(TD), .HITSTUN_TICKS(HS), .INVULN_TICKS(IV), .DMG_MAX(DM)) dut (
    .clock(clock), .reset(reset), .attack(attack), .attackerpos(attackerpos),
    .victimpos(victimpos), .clear_damage(clear_damage), .damage(damage),
    .knockback(knockback), .hitstun(hitstun), .invulnerable(invulnerable),
    .hit_type(hit_type), .hit_pulse(hit_pulse), .dbg_state(dbg_state)
  );

  int n_vec = 0, n_miss = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = free, 1 = stunned, 2 = invulnerable.
  int dmg_tab[11] = '{0, 15, 14, 16, 16, 3, 8, 10, 9, 9, 7};
  int kb_tab[11]  = '{0, 8, 8, 8, 8, 1, 4, 4, 4, 4, 4};
  int m_dmg = 0, m_vx = 0, m_vy = 0, m_type = 0, m_pulse = 0;
  int m_phase = 0, m_rem = 0, m_cnt = 0, m_prev = 0;
  int idx, base, mag, next_cnt;
  bit is_tick;

  always @(posedge clock) begin
    if (reset) begin
      m_dmg = 0; m_vx = 0; m_vy = 0; m_type = 0; m_pulse = 0;
      m_phase = 0; m_rem = 0; m_cnt = 0; m_prev = 0;
    end else begin
      is_tick  = (m_cnt == int'(TD) - 1);
      next_cnt = is_tick ? 0 : m_cnt + 1;
      idx = 0;
      for (int i = 10; i >= 1; i--) if (attack[i]) idx = i;
      m_pulse = 0;
      if (m_phase == 0 && attack[0] && m_prev == 0 && idx != 0) begin
        base  = clear_damage ? 0 : m_dmg;
        m_dmg = base + dmg_tab[idx];
        if (m_dmg > int'(DM)) m_dmg = int'(DM);
        mag = kb_tab[idx] + m_dmg / 16;
        if (mag > 127) mag = 127;
        case (idx)
          1, 6:    begin m_vx = 0;    m_vy = mag;  end
          2, 7:    begin m_vx = 0;    m_vy = -mag; end
          3, 8:    begin m_vx = -mag; m_vy = 0;    end
          4, 9:    begin m_vx = mag;  m_vy = 0;    end
          default: begin
            m_vx = (victimpos[31:16] >= attackerpos[31:16]) ? mag : -mag;
            m_vy = mag / 2;
          end
        endcase
        m_type = idx; m_pulse = 1; m_phase = 1; m_rem = int'(HS); next_cnt = 0;
      end else begin
        if (clear_damage) m_dmg = 0;
        if (is_tick && m_phase == 1) begin
          if (m_rem <= 1) begin
            m_vx = 0; m_vy = 0; m_phase = 2; m_rem = int'(IV);
          end else begin
            m_rem--;
            if (m_vx > 0) m_vx--; else if (m_vx < 0) m_vx++;
            if (m_vy > 0) m_vy--; else if (m_vy < 0) m_vy++;
          end
        end else if (is_tick && m_phase == 2) begin
          if (m_rem <= 1) m_phase = 0; else m_rem--;
        end
      end
      m_prev = attack[0];
      m_cnt  = next_cnt;
    end
  end

  logic [31:0] kexp;
  always @(negedge clock) begin
    if (cmp_en) begin
      kexp = {m_vx[15:0], m_vy[15:0]};
      check("m_damage", {22'd0, damage}, m_dmg);
      check("m_knockback", knockback, kexp);
      check("m_hitstun", {31'd0, hitstun}, (m_phase == 1) ? 1 : 0);
      check("m_invulnerable", {31'd0, invulnerable}, (m_phase != 0) ? 1 : 0);
      check("m_hit_type", {28'd0, hit_type}, m_type);
      check("m_hit_pulse", {31'd0, hit_pulse}, m_pulse);
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (m_phase != 0 && k < 200) begin @(negedge clock); k++; end
    if (m_phase != 0) begin
      n_vec++; n_miss++;
      $display("FAIL idle_timeout: phase %0d, required 0", m_phase);
    end
  endtask

  task automatic wait_phase(input int ph);
    int k = 0;
    while (m_phase != ph && k < 200) begin @(negedge clock); k++; end
    if (m_phase != ph) begin
      n_vec++; n_miss++;
      $display("FAIL phase_timeout: phase %0d, required %0d", m_phase, ph);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; attack = '0; clear_damage = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Drive one rising edge of the given attack word and return just after acceptance.
  task automatic strike(input logic [31:0] a);
    @(negedge clock); attack = a;
    @(negedge clock);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("reset_damage", {22'd0, damage}, 32'd0);
    check("reset_knockback", knockback, 32'd0);
    check("reset_flags", {28'd0, hitstun, invulnerable, hit_pulse, 1'b0}, 32'd0);
    check("reset_hit_type", {28'd0, hit_type}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0; cmp_en = 1'b1;

    // smashR from the left: full tick-by-tick trace
    victimpos = {16'd100, 16'd0}; attackerpos = {16'd80, 16'd0};
    strike(32'h11);
    check("smashR_damage", {22'd0, damage}, 32'd16);
    check("smashR_kb", knockback, 32'h0009_0000);
    check("smashR_type", {28'd0, hit_type}, 32'd4);
    check("smashR_pulse", {31'd0, hit_pulse}, 32'd1);
    check("smashR_stun", {31'd0, hitstun}, 32'd1);
    attack = '0;
    @(negedge clock); check("smashR_pulse_drop", {31'd0, hit_pulse}, 32'd0);
    repeat (3) @(negedge clock); check("smashR_tick1", knockback, 32'h0008_0000);
    repeat (4) @(negedge clock); check("smashR_tick2", knockback, 32'h0007_0000);
    repeat (4) @(negedge clock);
    check("smashR_tick3_kb", knockback, 32'd0);
    check("smashR_invuln", {30'd0, hitstun, invulnerable}, 32'd1);
    repeat (8) @(negedge clock); check("smashR_idle", {31'd0, invulnerable}, 32'd0);

    // held jab: one acceptance only; a fresh edge during INVULN is dropped
    @(negedge clock); attack = 32'h21;
    repeat (40) @(negedge clock);
    check("jab_held_damage", {22'd0, damage}, 32'd19);
    check("jab_held_type", {28'd0, hit_type}, 32'd5);
    attack = '0; wait_idle();
    strike(32'h21); wait_phase(2);
    attack = '0; @(negedge clock); attack = 32'h21;
    repeat (2) @(negedge clock);
    check("jab_invuln_damage", {22'd0, damage}, 32'd22);
    attack = '0; wait_idle();

    // saturation: 66 smashU hits reach 990, then smashD clips to 999
    do_reset();
    for (int i = 0; i < 66; i++) begin
      strike(32'h03); attack = '0; wait_idle();
    end
    check("pump_damage", {22'd0, damage}, 32'd990);
    strike(32'h05);
    check("sat_damage", {22'd0, damage}, 32'd999);
    check("sat_kb", knockback, 32'h0000_FFBA);
    attack = '0; wait_idle();

    // specialN aimed at a victim left of the attacker
    do_reset();
    victimpos = {16'd50, 16'd7}; attackerpos = {16'd60, 16'd0};
    strike(32'h401);
    check("specN_damage", {22'd0, damage}, 32'd7);
    check("specN_kb", knockback, 32'hFFFC_0002);
    check("specN_type", {28'd0, hit_type}, 32'd10);
    attack = '0; wait_idle();

    // multiple type bits and a typeless edge
    strike(32'h07);
    check("multi_damage", {22'd0, damage}, 32'd22);
    check("multi_type", {28'd0, hit_type}, 32'd1);
    attack = '0; wait_idle();
    strike(32'h01);
    check("typeless_pulse", {31'd0, hit_pulse}, 32'd0);
    check("typeless_damage", {22'd0, damage}, 32'd22);
    attack = '0;

    // clear together with smashL, then reset mid-HITSTUN
    @(negedge clock); attack = 32'h09; clear_damage = 1'b1;
    @(negedge clock); attack = '0; clear_damage = 1'b0;
    check("clear_hit_damage", {22'd0, damage}, 32'd16);
    check("clear_hit_kb", knockback, 32'hFFF7_0000);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midreset_outs", {damage, hit_type, hitstun, invulnerable, hit_pulse, dbg_state}, 32'd0);
    check("midreset_kb", knockback, 32'd0);
    reset = 1'b0;

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      attack = $urandom;
      attack[0] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) attack[10:1] = 10'(1 << $urandom_range(0, 9));
      victimpos   = {16'($urandom_range(0, 3)), 16'($urandom)};
      attackerpos = {16'($urandom_range(0, 3)), 16'($urandom)};
      clear_damage = ($urandom_range(0, 49) == 0);
      reset = ($urandom_range(0, 499) == 0);
    end
    @(negedge clock);
    reset = 1'b0; attack = '0; clear_damage = 1'b0;
    repeat (2) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
